// File: rtl/data_mem_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : data_mem_pkg
//  Description : Shared types and constants for the data memory with
//                initialisation sequencer: sequencer state encoding, the
//                default init table and the parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

  // Sequencer state encoding, explicit 2-bit width.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } seq_state_t;

  localparam int unsigned C_INIT_TABLE_LEN = 12;

  // Tap patterns, space and delimiter characters loaded after the clear pass.
  // Element 0 lands at INIT_BASE.
  localparam logic [7:0] C_INIT_TABLE [C_INIT_TABLE_LEN] = '{
    8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69,
    8'h5C, 8'h7E, 8'h7B, 8'h00, 8'h20, 8'h00
  };

  // Table lookup; entries past the end of the table read as zero so a larger
  // INIT_COUNT simply zero-fills the remainder.
  function automatic logic [7:0] init_entry(input int unsigned i);
    logic [3:0] w_i;
    w_i = i[3:0];
    if (i < C_INIT_TABLE_LEN) begin
      return C_INIT_TABLE[w_i];
    end
    return 8'h00;
  endfunction

  // Reduction XOR: 1 when the word holds an odd number of ones. Callers
  // zero-extend narrower words, which does not change the result.
  function automatic logic odd_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_seq_init.sv
`default_nettype none
// ============================================================================
//  Module      : mem_init_seq
//  Description : Initialisation sequencer. After reset it zeroes addresses
//                CLR_LO..DEPTH-1 one word per cycle, then writes the init
//                table to INIT_BASE.., then raises Ready.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   1   clock
//    rst      in   1   synchronous active-high reset
//    o_we     out  1   sequencer write strobe (combinational from state)
//    o_addr   out  AW  sequencer write address
//    o_data   out  DW  sequencer write data
//    o_ready  out  1   registered; sequence complete
//    o_busy   out  1   registered; inverse of o_ready
// ============================================================================
module mem_init_seq
  import data_mem_pkg::*;
#(
  parameter int DW         = 8,
  parameter int AW         = 8,
  parameter int CLR_LO     = 64,
  parameter int INIT_BASE  = 130,
  parameter int INIT_COUNT = 12
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_ready,
  output logic          o_busy
);

  localparam logic [AW-1:0] C_PTR_START = AW'(CLR_LO);
  // Terminal compare on the top address stops ptr before it can wrap.
  localparam logic [AW-1:0] C_PTR_LAST  = {AW{1'b1}};
  localparam logic [AW-1:0] C_IDX_LAST  = AW'(INIT_COUNT - 1);
  localparam logic [AW-1:0] C_INIT_BASE = AW'(INIT_BASE);

  seq_state_t    r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_idx;
  logic          r_ready;
  logic          r_busy;

  logic [7:0]    w_tbl_byte;
  logic [DW-1:0] w_init_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= C_PTR_START;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == C_PTR_LAST) begin
            r_state <= ST_INIT;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        ST_INIT: begin
          // Ready rises on the same edge as the final table write.
          if (r_idx == C_IDX_LAST) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_READY: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: restart the sequence.
          r_state <= ST_CLEAR;
          r_ptr   <= C_PTR_START;
          r_idx   <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign w_tbl_byte  = init_entry(32'(r_idx));
  assign w_init_data = DW'(w_tbl_byte);

  // Write port is decoded from the current state so the write lands on the
  // same edge that advances the counter. Reset suppresses the write.
  always_comb begin
    o_we   = 1'b0;
    o_addr = r_ptr;
    o_data = '0;
    if (!rst) begin
      case (r_state)
        ST_CLEAR: begin
          o_we = 1'b1;
        end
        ST_INIT: begin
          o_we   = 1'b1;
          o_addr = C_INIT_BASE + r_idx;
          o_data = w_init_data;
        end
        default: begin
          o_we = 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_busy  = r_busy;

endmodule : mem_init_seq
`default_nettype wire

// File: rtl/data_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_seq
//  Description : CPU data memory with asynchronous read, synchronous write,
//                a parity-protected address window (stored MSB is an even
//                parity bit) and a multi-cycle initialisation sequencer.
//  Revision    : 1.0 - initial release
//
//  Ports
//    Clk          in   1   clock
//    Reset        in   1   synchronous active-high reset
//    WriteEn      in   1   write strobe, honoured only when Ready
//    DataAddress  in   AW  read/write address
//    DataIn       in   DW  write data
//    DataOut      out  DW  combinational read data, 0 while Busy
//    ParityErr    out  1   combinational; odd parity on a window read
//    Ready        out  1   registered; init complete
//    Busy         out  1   registered; inverse of Ready
// ============================================================================
module data_mem_seq
  import data_mem_pkg::*;
#(
  parameter int DW         = 8,
  parameter int AW         = 8,
  parameter int CLR_LO     = 64,
  parameter int PAR_LO     = 64,
  parameter int PAR_HI     = 127,
  parameter int INIT_BASE  = 130,
  parameter int INIT_COUNT = 12
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WriteEn,
  input  logic [AW-1:0] DataAddress,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          ParityErr,
  output logic          Ready,
  output logic          Busy
);

  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] C_PAR_LO = AW'(PAR_LO);
  localparam logic [AW-1:0] C_PAR_HI = AW'(PAR_HI);

  logic [DW-1:0] r_core [DEPTH];

  logic          w_seq_we;
  logic [AW-1:0] w_seq_addr;
  logic [DW-1:0] w_seq_data;
  logic          w_ready;
  logic          w_busy;

  logic          w_in_win;
  logic          w_user_we;
  logic [DW-2:0] w_payload;
  logic [DW-1:0] w_par_word;
  logic [DW-1:0] w_wr_word;
  logic [DW-1:0] w_rd_word;

  mem_init_seq #(
    .DW         (DW),
    .AW         (AW),
    .CLR_LO     (CLR_LO),
    .INIT_BASE  (INIT_BASE),
    .INIT_COUNT (INIT_COUNT)
  ) u_init_seq (
    .clk     (Clk),
    .rst     (Reset),
    .o_we    (w_seq_we),
    .o_addr  (w_seq_addr),
    .o_data  (w_seq_data),
    .o_ready (w_ready),
    .o_busy  (w_busy)
  );

  // Shared decode: the same address selects both the write encode and the
  // read check.
  assign w_in_win = (DataAddress >= C_PAR_LO) && (DataAddress <= C_PAR_HI);

  // Inside the window the user MSB is discarded and replaced so the stored
  // word always has even parity.
  assign w_payload  = DataIn[DW-2:0];
  assign w_par_word = {odd_parity(64'(w_payload)), w_payload};
  assign w_wr_word  = w_in_win ? w_par_word : DataIn;

  // Reset wins over a same-cycle write, and nothing is accepted or queued
  // until the sequencer has finished.
  assign w_user_we = WriteEn & w_ready & ~Reset;

  // Sequencer and user port are mutually exclusive (user gated by Ready);
  // the priority order only keeps the mux well defined.
  always_ff @(posedge Clk) begin
    if (w_seq_we) begin
      r_core[w_seq_addr] <= w_seq_data;
    end else if (w_user_we) begin
      r_core[DataAddress] <= w_wr_word;
    end
  end

  assign w_rd_word = r_core[DataAddress];
  assign DataOut   = w_ready ? w_rd_word : '0;
  assign ParityErr = w_ready & w_in_win & odd_parity(64'(w_rd_word));

  assign Ready = w_ready;
  assign Busy  = w_busy;

endmodule : data_mem_seq
`default_nettype wire

// File: tb/tb_data_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_seq
//  Description : Directed self-checking bench for data_mem_seq. A second
//                instance with a widened parity window places the init
//                table inside the window so a stored odd-parity word can be
//                read back without a backdoor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_seq;

  logic       clk;
  logic       rst;
  logic       we;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       perr;
  logic       ready;
  logic       busy;

  logic       we2;
  logic [7:0] addr2;
  logic [7:0] din2;
  logic [7:0] dout2;
  logic       perr2;
  logic       ready2;
  logic       busy2;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_seq u_dut (
    .Clk         (clk),
    .Reset       (rst),
    .WriteEn     (we),
    .DataAddress (addr),
    .DataIn      (din),
    .DataOut     (dout),
    .ParityErr   (perr),
    .Ready       (ready),
    .Busy        (busy)
  );

  data_mem_seq #(.PAR_HI(200)) u_dut_win (
    .Clk         (clk),
    .Reset       (rst),
    .WriteEn     (we2),
    .DataAddress (addr2),
    .DataIn      (din2),
    .DataOut     (dout2),
    .ParityErr   (perr2),
    .Ready       (ready2),
    .Busy        (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_init(input int a);
    case (a)
      130: return 8'h60;
      131: return 8'h48;
      132: return 8'h78;
      133: return 8'h72;
      134: return 8'h6A;
      135: return 8'h69;
      136: return 8'h5C;
      137: return 8'h7E;
      138: return 8'h7B;
      139: return 8'h00;
      140: return 8'h20;
      141: return 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // Counts edges after Reset release until Ready; expects 204. Spot-checks
  // the busy-state outputs part-way through.
  task automatic run_to_ready(input string tag);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      tick();
      n++;
      if (ready) begin
        done = 1'b1;
      end else if (n == 50) begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " dout busy"}, 32'(dout), 32'd0);
        check({tag, " perr busy"}, 32'(perr), 32'd0);
        check({tag, " perr2 busy"}, 32'(perr2), 32'd0);
      end
    end
    check({tag, " latency"}, 32'(n), 32'd204);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    addr = 8'(a);
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic rd_chk(input int a, input logic [7:0] exp_d, input logic exp_p);
    addr = 8'(a);
    #1;
    check($sformatf("data[%0d]", a), 32'(dout), 32'(exp_d));
    check($sformatf("perr[%0d]", a), 32'(perr), 32'(exp_p));
  endtask

  // Write, then check the result in the same cycle after the edge.
  task automatic wr_chk(input int a, input logic [7:0] d, input logic [7:0] exp_d, input logic exp_p);
    wr(a, d);
    check($sformatf("wr data[%0d]", a), 32'(dout), 32'(exp_d));
    check($sformatf("wr perr[%0d]", a), 32'(perr), 32'(exp_p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    addr  = 8'd70;
    din   = 8'h00;
    we2   = 1'b0;
    addr2 = 8'd140;
    din2  = 8'h00;

    // Reset values
    tick();
    check("reset ready", 32'(ready), 32'd0);
    check("reset busy", 32'(busy), 32'd1);
    check("reset dout", 32'(dout), 32'd0);
    check("reset perr", 32'(perr), 32'd0);
    rst = 1'b0;

    // First init: latency and full region contents
    run_to_ready("init1");
    check("init1 busy", 32'(busy), 32'd0);
    for (int a = 64; a < 256; a++) begin
      addr = 8'(a);
      #1;
      check($sformatf("init core[%0d]", a), 32'(dout), 32'(exp_init(a)));
    end

    // Plain and parity-window writes, including window boundaries
    wr_chk(10,  8'hAA, 8'hAA, 1'b0);
    wr_chk(20,  8'h22, 8'h22, 1'b0);
    wr_chk(200, 8'h55, 8'h55, 1'b0);
    wr_chk(70,  8'h03, 8'h03, 1'b0);
    wr_chk(70,  8'h87, 8'h87, 1'b0);
    wr_chk(71,  8'h7F, 8'hFF, 1'b0);
    wr_chk(72,  8'h80, 8'h00, 1'b0);
    wr_chk(63,  8'h80, 8'h80, 1'b0);
    wr_chk(64,  8'h01, 8'h81, 1'b0);
    wr_chk(127, 8'h01, 8'h81, 1'b0);
    wr_chk(128, 8'h01, 8'h01, 1'b0);
    wr_chk(150, 8'h01, 8'h01, 1'b0);
    rd_chk(70, 8'h87, 1'b0);

    // Reset with a same-cycle write, then hammer addr 200 while busy
    rst  = 1'b1;
    we   = 1'b1;
    addr = 8'd20;
    din  = 8'h11;
    tick();
    check("reset2 ready", 32'(ready), 32'd0);
    check("reset2 busy", 32'(busy), 32'd1);
    check("reset2 dout", 32'(dout), 32'd0);
    check("reset2 perr", 32'(perr), 32'd0);
    rst  = 1'b0;
    addr = 8'd200;
    din  = 8'hFF;
    run_to_ready("init2");
    we = 1'b0;
    rd_chk(200, 8'h00, 1'b0);
    rd_chk(10,  8'hAA, 1'b0);
    rd_chk(20,  8'h22, 1'b0);
    rd_chk(63,  8'h80, 1'b0);
    rd_chk(70,  8'h00, 1'b0);
    rd_chk(130, 8'h60, 1'b0);

    // Reset on edge 100 of the sequence aborts and restarts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (99) tick();
    check("mid ready", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_to_ready("restart");

    // Odd-parity word inside the widened window
    check("win ready", 32'(ready2), 32'd1);
    addr2 = 8'd140;
    #1;
    check("win data[140]", 32'(dout2), 32'h20);
    check("win perr[140]", 32'(perr2), 32'd1);
    addr2 = 8'd130;
    #1;
    check("win data[130]", 32'(dout2), 32'h60);
    check("win perr[130]", 32'(perr2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_data_mem_seq
`default_nettype wire
